// File: rtl/serial_adder_seq_if.sv
// Operand/result handshake bundle for serial_adder_seq.
// Optional subtract control appears when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub_en;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum_out;
   logic             c_out;

`ifdef SERIAL_ADDER_SUB_EN
   modport master (
      output in_valid, a_in, b_in, c_in, sub_en, out_ready,
      input  in_ready, out_valid, sum_out, c_out
   );
   modport slave (
      input  in_valid, a_in, b_in, c_in, sub_en, out_ready,
      output in_ready, out_valid, sum_out, c_out
   );
`else
   modport master (
      output in_valid, a_in, b_in, c_in, out_ready,
      input  in_ready, out_valid, sum_out, c_out
   );
   modport slave (
      input  in_valid, a_in, b_in, c_in, out_ready,
      output in_ready, out_valid, sum_out, c_out
   );
`endif
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell, LSB-first, WIDTH clocks per operation.
// Define SERIAL_ADDER_SUB_EN to add a subtract mode (a - b via ~b and carry-in 1).
module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_adder_seq_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    count_q, count_d;

   logic             fa_sum;
   logic             fa_carry;

   assign fa_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
   assign fa_carry = (a_sr_q[0] & b_sr_q[0]) | (b_sr_q[0] & carry_q) | (carry_q & a_sr_q[0]);

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      carry_d  = carry_q;
      count_d  = count_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_sr_d   = bus.a_in;
               sum_sr_d = '0;
               count_d  = '0;
               state_d  = SHIFT;
`ifdef SERIAL_ADDER_SUB_EN
               b_sr_d   = bus.sub_en ? ~bus.b_in : bus.b_in;
               carry_d  = bus.sub_en ? 1'b1 : bus.c_in;
`else
               b_sr_d   = bus.b_in;
               carry_d  = bus.c_in;
`endif
            end
         end
         SHIFT: begin
            carry_d  = fa_carry;
            a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
            sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
            // The counter saturates on the last bit so it never leaves 0..WIDTH-1.
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         carry_q  <= carry_d;
         count_q  <= count_d;
      end
   end

   // Handshake flags and result gating decode the state register only.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum_out   = (state_q == DONE) ? sum_sr_q : '0;
   assign bus.c_out     = (state_q == DONE) ? carry_q  : 1'b0;

endmodule
